// File: rtl/wb_arbiter_n_if.sv
// ---------------------------------------------------------------------------
// wb_arbiter_n_if
//  Bundle of the arbiter's Wishbone B4 pipelined signals: the flattened
//  per-master (s_*) side, the single downstream (m_*) side and the grant
//  vector.
//  Modports:
//    master : the arbiter's view. It consumes the bus-master requests and
//             drives the downstream bus as its master.
//    slave  : the environment's view. This covers the pipeline masters plus
//             the external slave, i.e. everything around the arbiter.
//  Parameter:
//    NB_MASTERS : number of upstream masters. Master 0 occupies bit 0 / [31:0].
// ---------------------------------------------------------------------------
interface wb_arbiter_n_if #(
    parameter int unsigned NB_MASTERS = 2
) ();

    // upstream, one lane per master
    logic [32*NB_MASTERS-1:0] s_wb_adr_i;
    logic [32*NB_MASTERS-1:0] s_wb_dat_i;
    logic [32*NB_MASTERS-1:0] s_wb_dat_o;
    logic [NB_MASTERS-1:0]    s_wb_we_i;
    logic [4*NB_MASTERS-1:0]  s_wb_sel_i;
    logic [NB_MASTERS-1:0]    s_wb_stb_i;
    logic [NB_MASTERS-1:0]    s_wb_cyc_i;
    logic [NB_MASTERS-1:0]    s_wb_ack_o;
    logic [NB_MASTERS-1:0]    s_wb_stall_o;

    // downstream, towards the external slave
    logic [31:0]              m_wb_adr_o;
    logic [31:0]              m_wb_dat_o;
    logic                     m_wb_we_o;
    logic [3:0]               m_wb_sel_o;
    logic                     m_wb_stb_o;
    logic                     m_wb_cyc_o;
    logic [31:0]              m_wb_dat_i;
    logic                     m_wb_ack_i;
    logic                     m_wb_stall_i;

    // one-hot current owner, zero when idle
    logic [NB_MASTERS-1:0]    grant_o;

    modport master (
        input  s_wb_adr_i, s_wb_dat_i, s_wb_we_i, s_wb_sel_i, s_wb_stb_i, s_wb_cyc_i,
        output s_wb_dat_o, s_wb_ack_o, s_wb_stall_o,
        output m_wb_adr_o, m_wb_dat_o, m_wb_we_o, m_wb_sel_o, m_wb_stb_o, m_wb_cyc_o,
        input  m_wb_dat_i, m_wb_ack_i, m_wb_stall_i,
        output grant_o
    );

    modport slave (
        output s_wb_adr_i, s_wb_dat_i, s_wb_we_i, s_wb_sel_i, s_wb_stb_i, s_wb_cyc_i,
        input  s_wb_dat_o, s_wb_ack_o, s_wb_stall_o,
        input  m_wb_adr_o, m_wb_dat_o, m_wb_we_o, m_wb_sel_o, m_wb_stb_o, m_wb_cyc_o,
        output m_wb_dat_i, m_wb_ack_i, m_wb_stall_i,
        input  grant_o
    );

endinterface

// File: rtl/wb_arbiter_n.sv
// ---------------------------------------------------------------------------
// wb_arbiter_n
//  Arbiter that connects N pipelined Wishbone B4 masters to one slave.
//  Selection is either fixed priority (the lowest index wins) or round-robin.
//  Once a master is granted, it keeps the bus until it drops cyc; there is no
//  preemption. Every hand-over passes through one IDLE cycle in which
//  m_wb_cyc_o is low.
//  The arbiter counts requests that have been accepted but not yet acked. At
//  MAX_OUTSTANDING it stalls the granted master.
//  Ports:
//    clk_i : clock, rising edge
//    rst_i : asynchronous active-high reset
//    bus   : wb_arbiter_n_if.master, which carries the s_* lanes, the m_*
//            bus and grant_o
//  Parameters:
//    NB_MASTERS      : 2..8
//    ROUND_ROBIN     : 0 = fixed priority, 1 = round-robin
//    MAX_OUTSTANDING : 1..15
// ---------------------------------------------------------------------------
module wb_arbiter_n #(
    parameter int unsigned NB_MASTERS      = 2,
    parameter int unsigned ROUND_ROBIN     = 0,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    wb_arbiter_n_if.master  bus
);

    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned IW = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_GRANTED = 1'b1;

    logic [0:0]            state,       state_nxt;
    logic [NB_MASTERS-1:0] grant,       grant_nxt;
    logic [CW-1:0]         outstanding, outstanding_nxt;
    logic [IW-1:0]         rr_ptr,      rr_ptr_nxt;   // first index to search from

    logic                  found_c;
    logic [IW-1:0]         win_idx_c;
    logic [NB_MASTERS-1:0] win_c;
    int unsigned           scan_idx_c;
    logic                  held_c;
    logic                  cap_c;
    logic                  stb_c;
    logic                  accept_c;

    logic [31:0]              m_adr_c;
    logic [31:0]              m_dat_c;
    logic                     m_we_c;
    logic [3:0]               m_sel_c;
    logic                     m_cyc_c;
    logic [NB_MASTERS-1:0]    s_ack_c;
    logic [NB_MASTERS-1:0]    s_stall_c;
    logic [32*NB_MASTERS-1:0] s_dat_c;

    // Request scan. Round-robin starts at rr_ptr and wraps; fixed priority starts at 0.
    always_comb begin
        found_c    = 1'b0;
        win_idx_c  = '0;
        scan_idx_c = 0;
        for (int unsigned k = 0; k < NB_MASTERS; k++) begin
            if (ROUND_ROBIN != 0) begin
                scan_idx_c = (32'(rr_ptr) + k) % NB_MASTERS;
            end else begin
                scan_idx_c = k;
            end
            if (!found_c && bus.s_wb_cyc_i[IW'(scan_idx_c)]) begin
                found_c   = 1'b1;
                win_idx_c = IW'(scan_idx_c);
            end
        end
        win_c = found_c ? (NB_MASTERS'(1) << win_idx_c) : '0;
    end

    // Bus ownership and transfer bookkeeping
    assign held_c   = |(bus.s_wb_cyc_i & grant);
    assign cap_c    = (outstanding == CW'(MAX_OUTSTANDING));
    assign stb_c    = |(bus.s_wb_stb_i & grant) & ~cap_c;
    assign accept_c = stb_c & ~bus.m_wb_stall_i;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            grant       <= '0;
            outstanding <= '0;
            rr_ptr      <= '0;
        end else begin
            state       <= state_nxt;
            grant       <= grant_nxt;
            outstanding <= outstanding_nxt;
            rr_ptr      <= rr_ptr_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt       = state;
        grant_nxt       = grant;
        outstanding_nxt = outstanding;
        rr_ptr_nxt      = rr_ptr;
        case (state)
            ST_IDLE: begin
                outstanding_nxt = '0;
                if (found_c) begin
                    state_nxt  = ST_GRANTED;
                    grant_nxt  = win_c;
                    rr_ptr_nxt = IW'((32'(win_idx_c) + 1) % NB_MASTERS);
                end
            end
            ST_GRANTED: begin
                if (!held_c) begin
                    // A release abandons any in-flight acks.
                    state_nxt       = ST_IDLE;
                    grant_nxt       = '0;
                    outstanding_nxt = '0;
                end else if (accept_c && !bus.m_wb_ack_i) begin
                    outstanding_nxt = outstanding + CW'(1);
                end else if (!accept_c && bus.m_wb_ack_i && (outstanding != '0)) begin
                    outstanding_nxt = outstanding - CW'(1);
                end
            end
            default: begin
                state_nxt       = ST_IDLE;
                grant_nxt       = '0;
                outstanding_nxt = '0;
            end
        endcase
    end

    // Datapath muxing. grant is zero in IDLE, which forces the idle values on both sides.
    always_comb begin
        m_adr_c   = '0;
        m_dat_c   = '0;
        m_we_c    = 1'b0;
        m_sel_c   = '0;
        m_cyc_c   = 1'b0;
        s_ack_c   = '0;
        s_stall_c = '1;
        s_dat_c   = '0;
        for (int unsigned i = 0; i < NB_MASTERS; i++) begin
            if (grant[i]) begin
                m_adr_c                = bus.s_wb_adr_i[32*i +: 32];
                m_dat_c                = bus.s_wb_dat_i[32*i +: 32];
                m_we_c                 = bus.s_wb_we_i[i];
                m_sel_c                = bus.s_wb_sel_i[4*i +: 4];
                m_cyc_c                = bus.s_wb_cyc_i[i];
                s_ack_c[i]             = bus.m_wb_ack_i;
                s_stall_c[i]           = bus.m_wb_stall_i | cap_c;
                s_dat_c[32*i +: 32]    = bus.m_wb_dat_i;
            end
        end
    end

    assign bus.m_wb_adr_o   = m_adr_c;
    assign bus.m_wb_dat_o   = m_dat_c;
    assign bus.m_wb_we_o    = m_we_c;
    assign bus.m_wb_sel_o   = m_sel_c;
    assign bus.m_wb_cyc_o   = m_cyc_c;
    assign bus.m_wb_stb_o   = stb_c;
    assign bus.s_wb_ack_o   = s_ack_c;
    assign bus.s_wb_stall_o = s_stall_c;
    assign bus.s_wb_dat_o   = s_dat_c;
    assign bus.grant_o      = grant;

endmodule

// File: tb/tb_wb_arbiter_n.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter_n
//  Directed bench. It builds three arbiter configurations on one clock:
//    dut_a : 2 masters, fixed priority, cap 4
//    dut_b : 3 masters, round-robin, cap 4
//    dut_c : 2 masters, fixed priority, cap 2
//  Inputs change on the falling edge. Outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_wb_arbiter_n;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [2:0] rr_exp [4];

    wb_arbiter_n_if #(.NB_MASTERS(2)) bus_a ();
    wb_arbiter_n_if #(.NB_MASTERS(3)) bus_b ();
    wb_arbiter_n_if #(.NB_MASTERS(2)) bus_c ();

    wb_arbiter_n #(.NB_MASTERS(2), .ROUND_ROBIN(0), .MAX_OUTSTANDING(4))
        dut_a (.clk_i(clk), .rst_i(rst), .bus(bus_a));
    wb_arbiter_n #(.NB_MASTERS(3), .ROUND_ROBIN(1), .MAX_OUTSTANDING(4))
        dut_b (.clk_i(clk), .rst_i(rst), .bus(bus_b));
    wb_arbiter_n #(.NB_MASTERS(2), .ROUND_ROBIN(0), .MAX_OUTSTANDING(2))
        dut_c (.clk_i(clk), .rst_i(rst), .bus(bus_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        rr_exp[0] = 3'b001;
        rr_exp[1] = 3'b010;
        rr_exp[2] = 3'b100;
        rr_exp[3] = 3'b001;
        rst = 1'b1;

        bus_a.s_wb_adr_i = {32'h0000_2000, 32'h0000_1000};
        bus_a.s_wb_dat_i = {32'h0000_00D1, 32'h0000_00D0};
        bus_a.s_wb_we_i  = 2'b10;
        bus_a.s_wb_sel_i = {4'h3, 4'hF};
        bus_a.s_wb_stb_i = '0;
        bus_a.s_wb_cyc_i = '0;
        bus_a.m_wb_dat_i = '0;
        bus_a.m_wb_ack_i = 1'b0;
        bus_a.m_wb_stall_i = 1'b0;

        bus_b.s_wb_adr_i = '0;
        bus_b.s_wb_dat_i = '0;
        bus_b.s_wb_we_i  = '0;
        bus_b.s_wb_sel_i = '0;
        bus_b.s_wb_stb_i = '0;
        bus_b.s_wb_cyc_i = '0;
        bus_b.m_wb_dat_i = '0;
        bus_b.m_wb_ack_i = 1'b0;
        bus_b.m_wb_stall_i = 1'b0;

        bus_c.s_wb_adr_i = '0;
        bus_c.s_wb_dat_i = '0;
        bus_c.s_wb_we_i  = '0;
        bus_c.s_wb_sel_i = '0;
        bus_c.s_wb_stb_i = '0;
        bus_c.s_wb_cyc_i = '0;
        bus_c.m_wb_dat_i = '0;
        bus_c.m_wb_ack_i = 1'b0;
        bus_c.m_wb_stall_i = 1'b0;

        // Reset values
        @(negedge clk); #1;
        chk("rst_grant", 64'(bus_a.grant_o), 64'h0);
        chk("rst_stall", 64'(bus_a.s_wb_stall_o), 64'h3);
        chk("rst_mcyc", 64'(bus_a.m_wb_cyc_o), 64'h0);
        chk("rst_stall_b", 64'(bus_b.s_wb_stall_o), 64'h7);
        @(negedge clk);
        rst = 1'b0;

        // Fixed priority: both request; master 0 wins one cycle later
        @(negedge clk);
        bus_a.s_wb_cyc_i = 2'b11;
        #1;
        chk("fp_latency_grant", 64'(bus_a.grant_o), 64'h0);
        chk("fp_latency_mcyc", 64'(bus_a.m_wb_cyc_o), 64'h0);
        @(negedge clk); #1;
        chk("fp_grant0", 64'(bus_a.grant_o), 64'h1);
        chk("fp_mcyc", 64'(bus_a.m_wb_cyc_o), 64'h1);
        chk("fp_stall", 64'(bus_a.s_wb_stall_o), 64'h2);
        chk("fp_madr", 64'(bus_a.m_wb_adr_o), 64'h1000);
        chk("fp_msel", 64'(bus_a.m_wb_sel_o), 64'hF);
        chk("fp_mwe", 64'(bus_a.m_wb_we_o), 64'h0);
        chk("fp_mdat", 64'(bus_a.m_wb_dat_o), 64'hD0);

        // Pipelined read of 0x1000, 0x1004; acks two cycles after each request
        bus_a.s_wb_stb_i = 2'b01;
        #1;
        chk("pr_mstb", 64'(bus_a.m_wb_stb_o), 64'h1);
        @(negedge clk);
        bus_a.s_wb_adr_i[31:0] = 32'h0000_1004;
        #1;
        chk("pr_madr2", 64'(bus_a.m_wb_adr_o), 64'h1004);
        chk("pr_cnt1", 64'(dut_a.outstanding), 64'h1);
        @(negedge clk);
        bus_a.s_wb_stb_i = 2'b00;
        bus_a.m_wb_ack_i = 1'b1;
        bus_a.m_wb_dat_i = 32'h0000_00AA;
        #1;
        chk("pr_cnt2", 64'(dut_a.outstanding), 64'h2);
        chk("pr_ack1", 64'(bus_a.s_wb_ack_o), 64'h1);
        chk("pr_dat1", bus_a.s_wb_dat_o, 64'h0000_0000_0000_00AA);
        @(negedge clk);
        bus_a.m_wb_dat_i = 32'h0000_00BB;
        #1;
        chk("pr_ack2", 64'(bus_a.s_wb_ack_o), 64'h1);
        chk("pr_dat2", bus_a.s_wb_dat_o, 64'h0000_0000_0000_00BB);
        @(negedge clk);
        bus_a.m_wb_ack_i = 1'b0;
        #1;
        chk("pr_cnt0", 64'(dut_a.outstanding), 64'h0);
        chk("pr_noack", 64'(bus_a.s_wb_ack_o), 64'h0);

        // Master 0 releases; one IDLE cycle, then master 1 is granted
        bus_a.s_wb_cyc_i = 2'b10;
        #1;
        chk("rel_mcyc_low", 64'(bus_a.m_wb_cyc_o), 64'h0);
        chk("rel_grant_held", 64'(bus_a.grant_o), 64'h1);
        @(negedge clk); #1;
        chk("rel_idle_grant", 64'(bus_a.grant_o), 64'h0);
        chk("rel_idle_stall", 64'(bus_a.s_wb_stall_o), 64'h3);
        @(negedge clk); #1;
        chk("fp_grant1", 64'(bus_a.grant_o), 64'h2);
        chk("fp_madr1", 64'(bus_a.m_wb_adr_o), 64'h2000);
        chk("fp_mwe1", 64'(bus_a.m_wb_we_o), 64'h1);
        chk("fp_msel1", 64'(bus_a.m_wb_sel_o), 64'h3);

        // Abort: master 1 drops cyc with one request outstanding; a late ack is dropped
        bus_a.s_wb_stb_i = 2'b10;
        @(negedge clk);
        bus_a.s_wb_stb_i = 2'b00;
        #1;
        chk("ab_cnt1", 64'(dut_a.outstanding), 64'h1);
        bus_a.s_wb_cyc_i = 2'b00;
        @(negedge clk);
        bus_a.m_wb_ack_i = 1'b1;
        bus_a.m_wb_dat_i = 32'h0000_00CC;
        #1;
        chk("ab_grant", 64'(bus_a.grant_o), 64'h0);
        chk("ab_cnt0", 64'(dut_a.outstanding), 64'h0);
        chk("ab_noack", 64'(bus_a.s_wb_ack_o), 64'h0);
        chk("ab_nodat", bus_a.s_wb_dat_o, 64'h0);
        @(negedge clk);
        bus_a.m_wb_ack_i = 1'b0;

        // Round-robin: all three request, each releases after one transfer
        for (int k = 0; k < 4; k++) begin
            bus_b.s_wb_cyc_i = 3'b111;
            #1;
            chk($sformatf("rr_idle%0d", k), 64'(bus_b.grant_o), 64'h0);
            @(negedge clk); #1;
            chk($sformatf("rr_grant%0d", k), 64'(bus_b.grant_o), 64'(rr_exp[k]));
            bus_b.s_wb_stb_i = rr_exp[k];
            @(negedge clk);
            bus_b.s_wb_stb_i = 3'b000;
            bus_b.m_wb_ack_i = 1'b1;
            #1;
            chk($sformatf("rr_ack%0d", k), 64'(bus_b.s_wb_ack_o), 64'(rr_exp[k]));
            @(negedge clk);
            bus_b.m_wb_ack_i = 1'b0;
            bus_b.s_wb_cyc_i = 3'b111 & ~rr_exp[k];
            @(negedge clk);
        end

        // Cap of 2: the slave never acks, so only 2 of 4 strobes are accepted; one ack frees one slot
        bus_c.s_wb_cyc_i = 2'b01;
        @(negedge clk); #1;
        chk("cap_grant", 64'(bus_c.grant_o), 64'h1);
        bus_c.s_wb_stb_i = 2'b01;
        #1;
        chk("cap_stb1", 64'(bus_c.m_wb_stb_o), 64'h1);
        chk("cap_stall1", 64'(bus_c.s_wb_stall_o), 64'h2);
        @(negedge clk); #1;
        chk("cap_stb2", 64'(bus_c.m_wb_stb_o), 64'h1);
        @(negedge clk); #1;
        chk("cap_stb3_blocked", 64'(bus_c.m_wb_stb_o), 64'h0);
        chk("cap_stall_full", 64'(bus_c.s_wb_stall_o), 64'h3);
        @(negedge clk); #1;
        chk("cap_stb4_blocked", 64'(bus_c.m_wb_stb_o), 64'h0);
        bus_c.m_wb_ack_i = 1'b1;
        #1;
        chk("cap_ack", 64'(bus_c.s_wb_ack_o), 64'h1);
        chk("cap_stb_during_ack", 64'(bus_c.m_wb_stb_o), 64'h0);
        @(negedge clk);
        bus_c.m_wb_ack_i = 1'b0;
        #1;
        chk("cap_stb_freed", 64'(bus_c.m_wb_stb_o), 64'h1);
        chk("cap_stall_freed", 64'(bus_c.s_wb_stall_o), 64'h2);
        @(negedge clk); #1;
        chk("cap_stb_full_again", 64'(bus_c.m_wb_stb_o), 64'h0);
        bus_c.s_wb_stb_i = 2'b00;
        bus_c.s_wb_cyc_i = 2'b00;

        // Reset asserted mid-burst takes effect without waiting for a clock edge
        @(negedge clk);
        bus_a.s_wb_cyc_i = 2'b01;
        bus_a.s_wb_stb_i = 2'b01;
        @(negedge clk);
        @(negedge clk); #1;
        chk("mr_pre_cnt", 64'(dut_a.outstanding), 64'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_grant", 64'(bus_a.grant_o), 64'h0);
        chk("mr_mcyc", 64'(bus_a.m_wb_cyc_o), 64'h0);
        chk("mr_mstb", 64'(bus_a.m_wb_stb_o), 64'h0);
        chk("mr_stall", 64'(bus_a.s_wb_stall_o), 64'h3);
        chk("mr_cnt", 64'(dut_a.outstanding), 64'h0);
        bus_a.s_wb_cyc_i = 2'b00;
        bus_a.s_wb_stb_i = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
